tensorcore_tile_sequencer: RTL
==============================

TENSORCORE_TILE_SEQUENCER -- requirements
Module: tensorcore_tile_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles from issue to tc_out_valid before an error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: start a tile job; honoured in IDLE only.
REQ-005 SHALL have port start_e5m2mode, input, 1 bit: FP8 format for the job, latched on an accepted start.
REQ-006 SHALL have port load_data, input, 16 bits: operand beat; A/B beats use bits [7:0], C beats use all 16.
REQ-007 SHALL have ports load_valid (input, 1 bit) and load_ready (output, 1 bit): operand handshake; a beat transfers when both are high.
REQ-008 SHALL have port tc_a, output, 4x8 array of 8 bits: A tile to the tensor core.
REQ-009 SHALL have port tc_b, output, 8x4 array of 8 bits: B tile to the tensor core.
REQ-010 SHALL have port tc_c, output, 4x4 array of 16 bits: C tile to the tensor core.
REQ-011 SHALL have ports tc_e5m2mode and tc_in_valid, outputs, 1 bit each: tensor-core mode and issue strobe.
REQ-012 SHALL have port tc_d, input, 4x4 array of 16 bits: tensor-core result.
REQ-013 SHALL have port tc_out_valid, input, 1 bit: the tensor core's result strobe.
REQ-014 SHALL have ports res_data (output, 16 bits), res_valid (output, 1 bit) and res_ready (input, 1 bit): result stream.
REQ-015 SHALL have ports busy, done and timeout_err, outputs, 1 bit each: busy = not IDLE; done = one-cycle pulse; timeout_err = sticky.

Function
REQ-016 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_C, ISSUE, WAIT, DRAIN.
REQ-017 IDLE: start=1 SHALL latch the mode, clear timeout_err and the beat index, and go to LOAD_A.
REQ-018 load_ready SHALL be 1 only in the LOAD_* states.
REQ-019 LOAD_A: accept 32 beats, row-major; beat k writes tc_a[k/8][k%8], then go to LOAD_B.
REQ-020 LOAD_B: accept 32 beats, row-major; beat k writes tc_b[k/4][k%4], then go to LOAD_C.
REQ-021 LOAD_C: accept 16 beats; beat k writes tc_c[k/4][k%4], then go to ISSUE.
REQ-022 A/B beats SHALL discard load_data[15:8].
REQ-023 The beat index SHALL be 7 bits and SHALL clear at every state change.
REQ-024 ISSUE SHALL assert tc_in_valid for exactly one cycle, then go to WAIT.
REQ-025 tc_a/tc_b/tc_c/tc_e5m2mode SHALL hold stable from ISSUE until the job returns to IDLE.
REQ-026 WAIT: tc_out_valid=1 SHALL capture all 16 tc_d words into the result buffer and go to DRAIN.
REQ-027 WAIT timeout: if the WAIT cycle counter reaches TIMEOUT-1 without tc_out_valid, SHALL set timeout_err and go to IDLE with no drain and no done pulse.
REQ-028 DRAIN SHALL present result words row-major; res_data = D[k/4][k%4], with res_valid=1.
REQ-029 In DRAIN, res_data SHALL hold while res_ready=0.
REQ-030 After beat 15 is accepted, SHALL pulse done for one cycle and return to IDLE.
REQ-031 tc_out_valid outside WAIT SHALL be ignored.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 load_valid outside the LOAD_* states SHALL be ignored.
REQ-034 Minimum latency SHALL be 80 load cycles + 1 issue cycle + tensor-core latency + 16 drain cycles.

Reset
REQ-035 While rst=1, the state SHALL be IDLE, regardless of clock.
REQ-036 While rst=1, load_ready, tc_in_valid, res_valid, busy, done and timeout_err SHALL be 0.
REQ-037 While rst=1, res_data, the counters and all tile and result registers SHALL be 0.
REQ-038 Reset mid-job SHALL abandon the job.
REQ-039 A tc_out_valid arriving after reset SHALL NOT be captured.

Structure
REQ-040 The shared package tc_pkg SHALL hold the FP8/FP16 widths, tile dimensions (M=4, K=8, N=4) and the state enum.
REQ-041 The block SHALL be a single module with no sub-module; the tensor core is instantiated beside it by the integrator.

Verification
REQ-042 A=all 0x38, B=all 0x38, C=all 0x3C00 (e4m3), real tensor core -> 16 results 0x4880, then one done pulse.
REQ-043 load_valid toggled every other cycle -> still exactly 80 beats accepted; tile contents match row-major order.
REQ-044 res_ready low for 5 cycles mid-drain -> res_data stable throughout; no beat lost or duplicated.
REQ-045 Stub tensor core never asserts tc_out_valid, TIMEOUT=64 -> timeout_err=1 at cycle 64 of WAIT; IDLE; no done pulse.
REQ-046 rst asserted at LOAD_B beat 10 -> outputs 0 immediately; a fresh job afterwards completes correctly.
REQ-047 start pulsed during DRAIN, and tc_out_valid pulsed during LOAD_A -> both ignored; result stream unchanged.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared widths, tile shape and sequencer state codes
// for the tensor-core tile path.
package tc_pkg;

    localparam int FP8_W  = 8;
    localparam int FP16_W = 16;
    localparam int TC_M   = 4;
    localparam int TC_K   = 8;
    localparam int TC_N   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_LOAD_C = 3'd3;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_DRAIN  = 3'd6;

endpackage

// File: rtl/tensorcore_tile_sequencer.sv
// Streams A/B/C operand tiles into a 4x8x4 tensor core,
// issues one job, waits for the result and drains it.
module tensorcore_tile_sequencer
    import tc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   start_e5m2mode,
    input  logic [15:0]                            load_data,
    input  logic                                   load_valid,
    output logic                                   load_ready,
    output logic [TC_M-1:0][TC_K-1:0][FP8_W-1:0]   tc_a,
    output logic [TC_K-1:0][TC_N-1:0][FP8_W-1:0]   tc_b,
    output logic [TC_M-1:0][TC_N-1:0][FP16_W-1:0]  tc_c,
    output logic                                   tc_e5m2mode,
    output logic                                   tc_in_valid,
    input  logic [TC_M-1:0][TC_N-1:0][FP16_W-1:0]  tc_d,
    input  logic                                   tc_out_valid,
    output logic [15:0]                            res_data,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   timeout_err
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]     state;
    logic [6:0]     idx;
    logic [WCW-1:0] wcnt;
    logic           ld_hs;
    logic           last_ab;
    logic           last_c;

    logic [TC_M-1:0][TC_N-1:0][FP16_W-1:0] res_q;

    assign load_ready = (state == ST_LOAD_A) ||
                        (state == ST_LOAD_B) ||
                        (state == ST_LOAD_C);
    assign ld_hs       = load_valid && load_ready;
    assign last_ab     = (idx == 7'd31);
    assign last_c      = (idx == 7'd15);
    assign tc_in_valid = (state == ST_ISSUE);
    assign res_valid   = (state == ST_DRAIN);
    assign busy        = (state != ST_IDLE);
    assign res_data    = res_valid ? res_q[idx[3:2]][idx[1:0]] : '0;

    // Job control: state, beat index, wait counter, status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wcnt        <= '0;
            tc_e5m2mode <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tc_e5m2mode <= start_e5m2mode;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        state       <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (ld_hs) begin
                        if (last_ab) begin
                            idx   <= '0;
                            state <= (state == ST_LOAD_A) ?
                                     ST_LOAD_B : ST_LOAD_C;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                ST_LOAD_C: begin
                    if (ld_hs) begin
                        if (last_c) begin
                            idx   <= '0;
                            state <= ST_ISSUE;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    idx   <= '0;
                    wcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tc_out_valid) begin
                        idx   <= '0;
                        state <= ST_DRAIN;
                    end else if (wcnt == WCW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        idx         <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (res_ready) begin
                        if (last_c) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand tiles fill row-major; result tile snaps on tc_out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_a  <= '0;
            tc_b  <= '0;
            tc_c  <= '0;
            res_q <= '0;
        end else begin
            if (ld_hs && state == ST_LOAD_A)
                tc_a[idx[4:3]][idx[2:0]] <= load_data[7:0];
            if (ld_hs && state == ST_LOAD_B)
                tc_b[idx[4:2]][idx[1:0]] <= load_data[7:0];
            if (ld_hs && state == ST_LOAD_C)
                tc_c[idx[3:2]][idx[1:0]] <= load_data;
            if (state == ST_WAIT && tc_out_valid)
                res_q <= tc_d;
        end
    end

endmodule
